// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio amplitude path.
package audio_pkg;

    // Gate FSM states: CLOSED is silent, OPEN and HOLD both drive gate high.
    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        OPEN   = 2'd1,
        HOLD   = 2'd2
    } gate_state_t;

    // Magnitude of a sign-extended sample of width w, clamped to 2^(w-1)-1 so
    // the most-negative code does not wrap back to a negative-looking value.
    function automatic logic [63:0] sat_abs(input logic signed [63:0] x,
                                            input int unsigned        w);
        logic [63:0] mag;
        logic [63:0] limit;
        mag   = x[63] ? 64'(-x) : 64'(x);
        limit = (64'd1 << (w - 1)) - 64'd1;
        return (mag > limit) ? limit : mag;
    endfunction

endpackage

// File: rtl/envelope_follower_if.sv
// Sample stream in, envelope and gate out, plus the gate state for observation.
//
// Handshake: data_valid is a one-cycle strobe qualifying data_in; there is no
// ready, the follower accepts a sample on every cycle. env_valid is a one-cycle
// strobe qualifying env_out. gate is a level; gate_rise/gate_fall are pulses.
interface envelope_follower_if #(
    parameter int DATA_WIDTH = 32
);
    import audio_pkg::*;

    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         data_valid;
    logic        [DATA_WIDTH-1:0] env_out;
    logic                         env_valid;
    logic                         gate;
    logic                         gate_rise;
    logic                         gate_fall;
    gate_state_t                  state;

    modport master (
        output data_in, data_valid,
        input  env_out, env_valid, gate, gate_rise, gate_fall, state
    );

    modport slave (
        input  data_in, data_valid,
        output env_out, env_valid, gate, gate_rise, gate_fall, state
    );

endinterface

// File: rtl/env_smoother.sv
// Attack/release one-pole smoother on a rectified magnitude stream.
module env_smoother #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  abs_in,
    input  logic                   abs_valid,
    input  logic [SHIFT_WIDTH-1:0] attack_shift,
    input  logic [SHIFT_WIDTH-1:0] release_shift,
    output logic [DATA_WIDTH-1:0]  env_out,
    output logic                   env_valid
);

    logic [DATA_WIDTH-1:0] env_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] rise_diff;
    logic [DATA_WIDTH-1:0] fall_diff;
    logic [DATA_WIDTH-1:0] step;
    logic [DATA_WIDTH-1:0] env_next;

    assign rise_diff = abs_in - env_q;
    assign fall_diff = env_q - abs_in;

    // Step toward the input; a step that shifts down to zero is forced to 1 so
    // the envelope always converges. step <= diff, so it never overshoots.
    always_comb begin
        step     = '0;
        env_next = env_q;
        if (abs_in > env_q) begin
            step = rise_diff >> attack_shift;
            if (step == '0) step = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            env_next = env_q + step;
        end else if (abs_in < env_q) begin
            step = fall_diff >> release_shift;
            if (step == '0) step = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            env_next = env_q - step;
        end
    end

    // Commit the new envelope on each rectified sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            env_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= abs_valid;
            if (abs_valid) env_q <= env_next;
        end
    end

    assign env_out   = env_q;
    assign env_valid = valid_q;

endmodule

// File: rtl/envelope_follower.sv
// Rectifier, envelope smoother and hysteresis/hold gate for live audio.
module envelope_follower
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
    parameter int HOLD_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    envelope_follower_if.slave     bus,
    input  logic [SHIFT_WIDTH-1:0] attack_shift,
    input  logic [SHIFT_WIDTH-1:0] release_shift,
    input  logic [DATA_WIDTH-1:0]  open_thresh,
    input  logic [DATA_WIDTH-1:0]  close_thresh,
    input  logic [HOLD_WIDTH-1:0]  hold_len
);

    logic [DATA_WIDTH-1:0] abs_q;
    logic                  abs_valid_q;
    logic [DATA_WIDTH-1:0] env;
    logic                  env_valid;
    logic [DATA_WIDTH-1:0] close_eff;

    gate_state_t           state_q, state_next;
    logic [HOLD_WIDTH-1:0] cnt_q, cnt_next;
    logic                  rise_next, fall_next;
    logic                  gate_q, rise_q, fall_q;

    // Rectify on each incoming sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            abs_q       <= '0;
            abs_valid_q <= 1'b0;
        end else begin
            abs_valid_q <= bus.data_valid;
            if (bus.data_valid)
                abs_q <= DATA_WIDTH'(sat_abs(64'(bus.data_in), DATA_WIDTH));
        end
    end

    env_smoother #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_smoother (
        .clk           (clk),
        .rst           (rst),
        .abs_in        (abs_q),
        .abs_valid     (abs_valid_q),
        .attack_shift  (attack_shift),
        .release_shift (release_shift),
        .env_out       (env),
        .env_valid     (env_valid)
    );

    // A close level above the open level would make the gate chatter; clamp it.
    assign close_eff = (close_thresh < open_thresh) ? close_thresh : open_thresh;

    // Gate next-state: only advances on a fresh envelope value.
    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (env_valid) begin
            case (state_q)
                CLOSED: begin
                    if (env >= open_thresh) begin
                        state_next = OPEN;
                        rise_next  = 1'b1;
                    end
                end
                OPEN: begin
                    if (env < close_eff) begin
                        if (hold_len == '0) begin
                            state_next = CLOSED;
                            fall_next  = 1'b1;
                        end else begin
                            state_next = HOLD;
                            cnt_next   = hold_len;
                        end
                    end
                end
                HOLD: begin
                    if (env >= open_thresh) begin
                        state_next = OPEN;
                    end else if (cnt_q <= {{(HOLD_WIDTH-1){1'b0}}, 1'b1}) begin
                        state_next = CLOSED;
                        fall_next  = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_next = CLOSED;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Gate state and registered gate outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLOSED;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            gate_q  <= (state_next != CLOSED);
            rise_q  <= rise_next;
            fall_q  <= fall_next;
        end
    end

    assign bus.env_out   = env;
    assign bus.env_valid = env_valid;
    assign bus.gate      = gate_q;
    assign bus.gate_rise = rise_q;
    assign bus.gate_fall = fall_q;
    assign bus.state     = state_q;

endmodule

// File: doc/envelope_follower.md
Name: envelope_follower

Overview:
Amplitude detector for the audio path. It rectifies an incoming signed sample stream and smooths it with independent attack and release time constants to produce an amplitude envelope. A hysteresis-plus-hold gate FSM turns that envelope into a play/gate level with rise and fall pulses. The output is suitable for driving the play input of the envelope generator from live audio, such as an external input or a sidechain.

Parameters:
DATA_WIDTH, 32, sample width (signed input) and envelope/threshold width (unsigned).
SHIFT_WIDTH, $clog2(DATA_WIDTH), width of the attack/release shift controls.
HOLD_WIDTH, 32, width of the hold counter in samples.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
data_in  input  DATA_WIDTH  signed audio sample
data_valid  input  1  sample strobe, one cycle per sample
attack_shift  input  SHIFT_WIDTH  rise coefficient; step = diff >> attack_shift
release_shift  input  SHIFT_WIDTH  fall coefficient; step = diff >> release_shift
open_thresh  input  DATA_WIDTH  unsigned gate-open level
close_thresh  input  DATA_WIDTH  unsigned gate-close level
hold_len  input  HOLD_WIDTH  samples to hold the gate after the envelope drops below close level
env_out  output  DATA_WIDTH  unsigned envelope; MSB always 0
env_valid  output  1  env_out updated this cycle
gate  output  1  level; 1 in OPEN or HOLD
gate_rise  output  1  one-cycle pulse on CLOSED->OPEN
gate_fall  output  1  one-cycle pulse on entering CLOSED from OPEN or HOLD

Behaviour:
- Reset: env_out=0, env_valid=0, gate=0, gate_rise=0, gate_fall=0, FSM=CLOSED, hold counter=0. All in-flight pipeline data is discarded. A reset mid-operation behaves identically.
- Stage 1, rectify: registered on data_valid. abs = |data_in|, saturating: the most-negative input maps to 2^(DATA_WIDTH-1)-1.
- Stage 2, smooth: registered one cycle after stage 1.
  - If abs > env: step = (abs-env) >> attack_shift; env += step.
  - If abs < env: step = (env-abs) >> release_shift; env -= step.
  - If the computed step is 0 while diff != 0, step = 1, so the envelope always converges.
  - If abs == env: env is unchanged.
  - env never overshoots abs.
  - All arithmetic is unsigned DATA_WIDTH.
  - env_valid pulses high with the new env_out exactly 2 cycles after data_valid.
- Shift and threshold inputs are sampled at the stage that uses them; they may change between samples.
- Gate FSM: evaluated in the cycle env_valid is high, using the new env. gate, gate_rise and gate_fall register 1 cycle later (3 cycles after data_valid).
  - close_eff = min(close_thresh, open_thresh).
  - CLOSED:
    - env >= open_thresh -> OPEN, gate_rise.
    - Otherwise stay.
  - OPEN:
    - env < close_eff and hold_len == 0 -> CLOSED, gate_fall.
    - env < close_eff and hold_len != 0 -> HOLD; counter = hold_len.
    - Otherwise stay.
  - HOLD:
    - env >= open_thresh -> OPEN, no pulse, gate stays 1.
    - Otherwise, counter == 1 -> CLOSED, gate_fall.
    - Otherwise counter decrements (once per env_valid).
    - env rising above close_eff but staying below open_thresh does not cancel the hold.
- Pulse rules: gate_rise and gate_fall are never high together and are each high for exactly 1 cycle.
- Back-to-back data_valid on every cycle is supported at full throughput. No backpressure.

Decomposition:
- audio_pkg: gate_state_t enum {CLOSED, OPEN, HOLD}; a saturating-abs function.
- Sub-module env_smoother: stage 2 arithmetic, including the minimum-step rule. The FSM and rectifier stay in the top level.

Test Plan:
- DATA_WIDTH=16, attack_shift=0, hold 0, data_in=1000 once -> env_out=1000 with env_valid exactly 2 cycles after data_valid.
- data_in=-32768 with attack_shift=0 -> env_out=32767, with no wrap to a negative value.
- env=1000, release_shift=2, data_in=0 for three samples -> env_out 750, 563, 423.
- env=3, release_shift=4, zero input -> 2, 1, 0, then stays 0 (minimum-step rule).
- open=500, close=200, hold=3, attack_shift=0, release_shift=0; inputs 600, 100, 100, 100, 100 -> gate_rise 3 cycles after the 600 sample; gate high through HOLD; gate_fall after the 4th 100 sample (3 held samples); gate then 0.
- In HOLD with counter=2, input 600 -> back to OPEN, no pulses, gate stays 1. Asserting rst mid-HOLD -> next cycle gate=0, env_out=0, env_valid=0, no gate_fall pulse.
